// File: rtl/log_top.sv
// Fixed-point ln(y) engine, y in [1.0, 1.5] Q2.16 -> Q0.16, Maclaurin series one term per clock.
// Build option: define LOG_ROUND_EN to round (half-up) both product shifts instead of truncating.
module log_top #(
    parameter int unsigned TERMS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] xBus,
    output logic [15:0] rBus,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [3:0]  LAST   = 4'(TERMS);
    localparam logic [17:0] X_MIN  = 18'h10000;
    localparam logic [17:0] X_MAX  = 18'h18000;

    state_t             state, state_n;
    logic        [3:0]  k, k_n;
    logic        [15:0] p, p_n;
    logic        [15:0] u, u_n;
    logic signed [19:0] acc, acc_n;
    logic        [15:0] rbus_n;
    logic               done_n, err_n;

    logic        [17:0] x_off;
    logic        [31:0] prod_t, prod_p;
    logic        [15:0] term;
    logic signed [19:0] acc_upd;
    logic               legal;

    // floor(65536 / k); k = 1 does not fit 16 bits and bypasses the multiplier
    function automatic logic [15:0] recip(input logic [3:0] idx);
        case (idx)
            4'd2:    recip = 16'd32768;
            4'd3:    recip = 16'd21845;
            4'd4:    recip = 16'd16384;
            4'd5:    recip = 16'd13107;
            4'd6:    recip = 16'd10922;
            4'd7:    recip = 16'd9362;
            4'd8:    recip = 16'd8192;
            4'd9:    recip = 16'd7281;
            4'd10:   recip = 16'd6553;
            4'd11:   recip = 16'd5957;
            4'd12:   recip = 16'd5461;
            4'd13:   recip = 16'd5041;
            4'd14:   recip = 16'd4681;
            4'd15:   recip = 16'd4369;
            default: recip = 16'd0;
        endcase
    endfunction

    always_comb begin
        x_off = xBus - X_MIN;
        legal = (xBus >= X_MIN) && (xBus <= X_MAX);
`ifdef LOG_ROUND_EN
        prod_t = 32'(p) * 32'(recip(k)) + 32'h8000;
        prod_p = 32'(p) * 32'(u) + 32'h8000;
`else
        prod_t = 32'(p) * 32'(recip(k));
        prod_p = 32'(p) * 32'(u);
`endif
        term    = (k == 4'd1) ? p : prod_t[31:16];
        acc_upd = k[0] ? (acc + $signed({4'b0, term})) : (acc - $signed({4'b0, term}));
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        p_n     = p;
        u_n     = u;
        acc_n   = acc;
        rbus_n  = rBus;
        done_n  = done;
        err_n   = err;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (legal) begin
                        u_n     = x_off[15:0];
                        p_n     = x_off[15:0];
                        acc_n   = '0;
                        k_n     = 4'd1;
                        done_n  = 1'b0;
                        err_n   = 1'b0;
                        state_n = CALC;
                    end else begin
                        rbus_n  = '0;
                        err_n   = 1'b1;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            CALC: begin
                acc_n = acc_upd;
                p_n   = prod_p[31:16];
                k_n   = k + 4'd1;
                if (k == LAST) begin
                    if (acc_upd[19])
                        rbus_n = '0;
                    else if (acc_upd[18:16] != 3'b000)
                        rbus_n = '1;
                    else
                        rbus_n = acc_upd[15:0];
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            p     <= '0;
            u     <= '0;
            acc   <= '0;
            rBus  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            p     <= p_n;
            u     <= u_n;
            acc   <= acc_n;
            rBus  <= rbus_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

endmodule

// File: doc/log_top.md
# log_top

Fixed-point natural-logarithm engine; inverse companion of the exponential Maclaurin block. Accepts an unsigned Q2.16 operand y in [1.0, 1.5] and evaluates ln(y) = ln(1+u), u = y - 1, with the alternating Maclaurin series u - u²/2 + u³/3 - ..., one term per clock. Uses the same start/done handshake and bus formats as the exponential engine, so the exponential result bus can drive this block's input for round-trip checking.

## Interface
- TERMS, 12, number of series terms evaluated; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- xBus  input  18  operand y, unsigned Q2.16 (0x10000 = 1.0).
- rBus  output  16  ln(y), unsigned Q0.16; reset 0x0000.
- done  output  1  result valid, level; reset 0.
- err  output  1  operand out of range; reset 0.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE, term counter k = 0, power p = 0, acc = 0, rBus = 0, done = 0, err = 0.
- IDLE/DONE with start = 1 (edge E0):
  - Range check: legal iff 0x10000 <= xBus <= 0x18000.
  - Legal: u = xBus - 0x10000 (16 bits); p = u; acc = 0; k = 1; done = 0; err = 0; → CALC.
  - Illegal: rBus = 0, err = 1, done = 1; → DONE (no CALC).
- CALC, each edge, term k:
  - term = p for k = 1; otherwise term = (p × R[k]) >> 16, R[k] = floor(65536 / k) from a 15-entry constant table.
  - acc += term (k odd); acc -= term (k even). acc is 20-bit signed.
  - p = (p × u) >> 16 (16×16 → 32, keep bits 31:16).
  - k = k + 1. When k == TERMS: rBus = clamp(acc, 0, 0xFFFF), done = 1, → DONE.
- Two 16×16 multipliers operate in parallel in the same cycle.
- DONE: rBus, done and err hold until next accepted start or rst.
- start in CALC is ignored; operand is captured only at E0, so xBus may change freely afterwards.
- rst in any state, including mid-CALC, returns all state and outputs to reset values on the next edge; a start asserted together with rst is dropped.

## Timing
- Legal operand: done rises TERMS edges after E0 (12 cycles by default); rBus valid in the same cycle.
- Illegal operand: done and err rise 1 edge after E0.
- Restart from DONE: done falls at E0 of the new request; the prior rBus is held until the new result is written.
- Back-to-back throughput: one result per TERMS + 1 cycles, with start asserted in the cycle done is first seen.
- Accuracy at TERMS = 12 over the legal range: within ±3 LSB of round(ln(y) × 65536).

## Configuration
- LOG_ROUND_EN defined: both product shifts add 0x8000 before >> 16 (round half-up). Accuracy tightens to ±1 LSB at TERMS = 12.
- LOG_ROUND_EN undefined: pure truncation as described above. Tolerance is ±3 LSB.
- Latency and handshake are identical in both builds.

## Test plan
- xBus = 0x10000, start one cycle → done after 12 cycles, rBus = 0x0000, err = 0.
- xBus = 0x12000 (1.125) → rBus = 0x1E27 ± tol; xBus = 0x14000 (1.25) → rBus = 0x3920 ± tol; xBus = 0x18000 (1.5) → rBus = 0x67CD ± tol.
- xBus = 0x0C000 (0.75), then separately 0x20000 (2.0) → done and err high 1 cycle after start, rBus = 0x0000.
- Start 0x14000. Pulse start with 0x18000 at cycle 5 of CALC → ignored; result is 0x3920 ± tol at cycle 12. Then start 0x18000 from DONE → done drops immediately, 0x67CD ± tol after 12 cycles.
- Start 0x18000, assert rst at cycle 6 → next edge rBus = 0, done = 0, err = 0, state IDLE. A new start then produces a correct result.
- Round trip: feed the exponential engine result for x = 0.25 (≈0x148B5) into xBus → rBus ≈ 0x4000 within ±4 LSB.
